// File: rtl/layer_mixer_pkg.sv
// Shared constants and types for the sprite layer compositor.
package layer_mixer_pkg;

    localparam int unsigned NUM_LAYERS_DEF = 4;
    localparam int unsigned LAT_DEF        = 2;

    // Background colour, RGB order (R in the top byte).
    localparam logic [23:0] BG_COLOR = 24'h000010;

    localparam int unsigned LAYER_PADDLE = 0;
    localparam int unsigned LAYER_BALL   = 1;
    localparam int unsigned LAYER_ENEMY  = 2;
    localparam int unsigned LAYER_SCORE  = 3;

    // Pixel triple, element 0 = blue, 1 = green, 2 = red.
    typedef logic [7:0] bgr_t [0:2];

    localparam bgr_t BG_BGR = '{BG_COLOR[7:0], BG_COLOR[15:8], BG_COLOR[23:16]};

endpackage

// File: rtl/layer_mixer_if.sv
// Pixel/timing bundle between the sprite generators, the mixer and the video encoder.
interface layer_mixer_if
    import layer_mixer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF
) ();

    localparam int unsigned IDX_W = $clog2(NUM_LAYERS);

    logic                  fsync;
    logic [NUM_LAYERS-1:0] layer_en;
    logic [NUM_LAYERS-1:0] layer_active;
    bgr_t                  layer_pixel [0:NUM_LAYERS-1];
    logic                  vde_in;
    logic                  hsync_in;
    logic                  vsync_in;

    bgr_t                  pixel_out;
    logic                  vde_out;
    logic                  hsync_out;
    logic                  vsync_out;
    logic [IDX_W-1:0]      top_layer;
    logic                  top_valid;
    logic [NUM_LAYERS-1:0] collision;

    modport master (
        output fsync, layer_en, layer_active, layer_pixel, vde_in, hsync_in, vsync_in,
        input  pixel_out, vde_out, hsync_out, vsync_out, top_layer, top_valid, collision
    );

    modport slave (
        input  fsync, layer_en, layer_active, layer_pixel, vde_in, hsync_in, vsync_in,
        output pixel_out, vde_out, hsync_out, vsync_out, top_layer, top_valid, collision
    );

endinterface

// File: rtl/layer_prio_enc.sv
// Lowest-index-wins priority encoder over the effective layer mask.
module layer_prio_enc #(
    parameter  int unsigned NUM_LAYERS = 4,
    localparam int unsigned IDX_W      = $clog2(NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0] req,
    output logic [IDX_W-1:0]      idx,
    output logic                  any
);

    // Scan from the top down so the last hit is the lowest set index.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_mixer.sv
// Two-stage fixed-priority sprite compositor with blanking and aligned video timing.
// Optional per-frame overlap flags against the paddle layer: define LAYER_MIXER_COLLISION_EN.
module layer_mixer
    import layer_mixer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int unsigned LAT        = LAT_DEF
) (
    input logic          pixel_clk,
    input logic          rst,
    layer_mixer_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_LAYERS);

    if (LAT != 2) begin : g_bad_lat
        $error("layer_mixer: LAT must be 2");
    end
    if (NUM_LAYERS < 2 || NUM_LAYERS > 8) begin : g_bad_layers
        $error("layer_mixer: NUM_LAYERS must be in 2..8");
    end

    logic [NUM_LAYERS-1:0] en_q;
    logic [NUM_LAYERS-1:0] eff;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_any;
    bgr_t                  win_pix;

    logic [IDX_W-1:0]      s1_idx;
    logic                  s1_any;
    bgr_t                  s1_pix;
    logic                  s1_vde;
    logic                  s1_hs;
    logic                  s1_vs;

    bgr_t                  pix_q;
    logic                  vde_q;
    logic                  hs_q;
    logic                  vs_q;
    logic [IDX_W-1:0]      top_layer_q;
    logic                  top_valid_q;

    // Enable mask only moves at frame start so a frame never tears.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            en_q <= '1;
        end else if (bus.fsync) begin
            en_q <= bus.layer_en;
        end
    end

    assign eff = bus.layer_active & en_q;

    layer_prio_enc #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_prio_enc (
        .req (eff),
        .idx (win_idx),
        .any (win_any)
    );

    assign win_pix = bus.layer_pixel[win_idx];

    // Stage 1: winner selection and timing capture.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            s1_idx <= '0;
            s1_any <= 1'b0;
            s1_pix <= '{default: 8'h00};
            s1_vde <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
        end else begin
            s1_idx <= win_idx;
            s1_any <= win_any;
            s1_pix <= win_pix;
            s1_vde <= bus.vde_in;
            s1_hs  <= bus.hsync_in;
            s1_vs  <= bus.vsync_in;
        end
    end

    // Stage 2: blanking / background fill.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            pix_q       <= '{default: 8'h00};
            vde_q       <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            top_layer_q <= '0;
            top_valid_q <= 1'b0;
        end else begin
            vde_q       <= s1_vde;
            hs_q        <= s1_hs;
            vs_q        <= s1_vs;
            top_layer_q <= s1_idx;
            top_valid_q <= s1_any & s1_vde;
            if (!s1_vde) begin
                pix_q <= '{default: 8'h00};
            end else if (s1_any) begin
                pix_q <= s1_pix;
            end else begin
                pix_q <= BG_BGR;
            end
        end
    end

    assign bus.pixel_out = pix_q;
    assign bus.vde_out   = vde_q;
    assign bus.hsync_out = hs_q;
    assign bus.vsync_out = vs_q;
    assign bus.top_layer = top_layer_q;
    assign bus.top_valid = top_valid_q;

`ifdef LAYER_MIXER_COLLISION_EN
    logic [NUM_LAYERS-1:0] hits;
    logic [NUM_LAYERS-1:0] acc_q;
    logic [NUM_LAYERS-1:0] coll_q;

    // Overlap of each lower layer with the paddle during active video.
    always_comb begin
        hits = '0;
        for (int i = 1; i < int'(NUM_LAYERS); i++) begin
            hits[i] = bus.vde_in & eff[LAYER_PADDLE] & eff[i];
        end
    end

    // A hit on the fsync cycle itself seeds the new frame's accumulator.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            acc_q  <= '0;
            coll_q <= '0;
        end else if (bus.fsync) begin
            coll_q <= acc_q;
            acc_q  <= hits;
        end else begin
            acc_q  <= acc_q | hits;
        end
    end

    assign bus.collision = coll_q;
`else
    assign bus.collision = '0;
`endif

endmodule

// File: doc/layer_mixer.md
Name: layer_mixer

Overview:
- Downstream of paddle and the other sprite generators (ball, enemies, score); consumes each generator's pixel/active pair.
- Produces one composited BGR pixel per pixel_clk.
- Resolves layers by fixed priority, forces black outside the active video region, and delays the video timing signals so they stay aligned with the colour.
- Its output feeds the video encoder directly.

Parameters:
- NUM_LAYERS, 4: number of sprite layers. Index 0 has the highest priority. Legal range 2..8.
- LAT, 2: pipeline latency in cycles. Fixed; exposed for bench alignment only, and the RTL asserts LAT==2.

Ports:
- pixel_clk  in  1  pixel clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- fsync  in  1  frame sync; single-cycle pulse at start of frame.
- layer_en  in  NUM_LAYERS  per-layer enable request; sampled only on fsync.
- layer_active  in  NUM_LAYERS  per-layer "pixel belongs to me".
- layer_pixel  in  NUM_LAYERS x 3 x 8  per-layer colour, unpacked [0:NUM_LAYERS-1][0:2], BGR (element 0 = blue).
- vde_in  in  1  active-video qualifier, aligned with the layer inputs.
- hsync_in  in  1  horizontal sync, aligned with vde_in.
- vsync_in  in  1  vertical sync, aligned with vde_in.
- pixel_out  out  3 x 8  composited colour, BGR, unpacked [0:2].
- vde_out  out  1  vde_in delayed by LAT.
- hsync_out  out  1  hsync_in delayed by LAT.
- vsync_out  out  1  vsync_in delayed by LAT.
- top_layer  out  $clog2(NUM_LAYERS)  index of the winning layer, aligned with pixel_out.
- top_valid  out  1  high when some enabled layer won the pixel.
- collision  out  NUM_LAYERS  per-frame overlap flags. Only driven when COLLISION_EN is defined.

Behaviour:
- Reset values: pixel_out=0, vde_out=hsync_out=vsync_out=0, top_layer=0, top_valid=0, collision=0, enable mask=all ones.
- Enable mask:
  - en_q <= layer_en on a cycle where fsync=1; otherwise en_q holds.
  - Mid-frame changes to layer_en have no effect until the next fsync, so there is no tearing.
- Stage 1 (registered):
  - eff = layer_active & en_q.
  - Priority-encode eff; the lowest set index wins.
  - Register the winning index, any(eff), the winning layer's colour, and vde/hsync/vsync.
  - Priority uses en_q as held before the update; a new mask takes effect from the cycle after the fsync cycle.
- Stage 2 (registered):
  - If vde=0: pixel_out=0.
  - Else if any=1: pixel_out = winning colour.
  - Else: pixel_out = BG_COLOR.
  - top_valid = any & vde.
  - Syncs, vde and top_layer pass through unchanged.
- Latency is exactly 2 cycles for every output; there are no stalls and no handshake, and a new pixel is accepted every cycle.
- Simultaneous layers: only the winner is visible; lower layers are ignored entirely, including their colour.
- All layers disabled: the background is shown during vde, black otherwise.
- Reset mid-frame: the pipeline flushes to zero. Outputs are valid again 2 cycles after rst deasserts. en_q returns to all ones.

Optional Feature:
- Macro: LAYER_MIXER_COLLISION_EN.
- Defined:
  - acc[i] sets when vde_in & eff[0] & eff[i], for i in 1..NUM_LAYERS-1; acc[0] is always 0.
  - On fsync: collision <= acc, and acc clears.
  - An overlap on the fsync cycle itself counts toward the new frame.
  - collision holds for a full frame. Game logic uses it for paddle–ball hits.
- Undefined: acc is absent and collision is tied to 0.

Decomposition:
- Package params gains:
  - BG_COLOR (24-bit RGB, default 24'h000010).
  - NUM_LAYERS default.
  - Layer index constants: LAYER_PADDLE=0, LAYER_BALL=1, LAYER_ENEMY=2, LAYER_SCORE=3.
  - Typedef for a pixel triple, bgr_t = logic [7:0] [0:2].
- One sub-module, layer_prio_enc: combinational lowest-index priority encoder, NUM_LAYERS bits in, outputs index and any.

Test Plan:
- Priority: layer_active=4'b0110, layer_en all ones, vde=1, layer1 colour BGR {11,22,33}, layer2 colour {44,55,66} -> 2 cycles later pixel_out={11,22,33}, top_layer=1, top_valid=1.
- Blanking: vde_in=0 with layer_active=4'b1111 -> pixel_out={0,0,0} and top_valid=0. With vde_in=1 and active=0 -> pixel_out = BG_COLOR bytes {10,00,00}.
- Mask timing: layer_en=4'b1110 driven mid-frame, layer0 active -> layer0 still wins until fsync. From the cycle after fsync -> layer1 wins where both layers are active.
- Sync alignment: pulse hsync_in for 1 cycle at cycle N -> hsync_out high exactly at N+2; vde and vsync are checked identically.
- Reset mid-stream: assert rst for 1 cycle while pixels are flowing -> all outputs are 0 during the following 2 cycles and en_q returns to all ones.
- Collision (LAYER_MIXER_COLLISION_EN defined): layers 0 and 1 overlap for 5 pixels in frame k -> after fsync, collision=4'b0010 for all of frame k+1. With no overlap in frame k+1 -> collision=0 after the following fsync.
